branch_predictor_f: RTL and testbench
=====================================

Name: branch_predictor_f

Overview:
Fetch-stage branch predictor. It sits directly upstream of the fetch PC register and supplies that register's predicted-taken select and predicted target each cycle. It is a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. Lookup is combinational on the current fetch PC. Training happens from the resolved-branch update port driven by decode.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, >= 2.
IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
TAG_W, 30-IDX_W, tag width; derived, not overridden.

Ports:
iClk  input  1  clock, rising edge.
iRst  input  1  synchronous, active-high reset.
iPCF  input  32  current fetch PC (PC register output).
oPredTakenF  output  1  predicted taken; drives the PC register's fetch-select input.
oPredTargetF  output  32  predicted target; drives the PC register's branch-target input.
oHitF  output  1  valid entry with matching tag for iPCF.
iUpdateEn  input  1  a conditional branch resolved this cycle.
iUpdatePC  input  32  PC of the resolved branch.
iUpdateTaken  input  1  actual outcome of the resolved branch.
iUpdateTarget  input  32  actual taken target of the resolved branch.

Behaviour:
- Address split:
  - index = PC[IDX_W+1:2]
  - tag = PC[31:IDX_W+2]
  - PC[1:0] is ignored on both ports.
- Per-entry state: valid (1 bit), tag (TAG_W bits), target (32 bits), ctr (2 bits).
  - Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup is purely combinational, with zero-cycle latency from iPCF to outputs:
  - oHitF = valid[idx] & (tag[idx] == iPCF tag).
  - oPredTakenF = oHitF & ctr[idx][1].
  - oPredTargetF = target[idx] when oHitF, else 32'h0.
- Update is sequential and takes effect on the rising edge where iUpdateEn=1 and iRst=0:
  - Hit, taken: ctr saturating increment (11 stays 11); target <= iUpdateTarget.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace the entry. valid<=1, tag<=update tag, target<=iUpdateTarget, ctr<=10.
  - Miss, not taken: no state change.
- iUpdateEn=0: no state change.
- Read/write ordering: no bypass. A lookup whose index equals the update index in the same cycle sees pre-update contents. The new contents are visible from the cycle after the edge.
- Reset, on any rising edge with iRst=1:
  - All valid bits <= 0, all ctr <= 01, all targets <= 0, all tags <= 0.
  - Reset has priority over a simultaneous update; that update is dropped.
- Outputs after reset edge: oHitF=0, oPredTakenF=0, oPredTargetF=0 for every iPCF, until the first taken update.
- Reset asserted mid-training clears all learned state; no partial entries survive.
- The predictor does not observe fetch stall. A stalled fetch PC simply re-reads the same entry. A mispredict recovery in the PC register needs no action here beyond the normal update.
- All writes are confined to the single indexed entry. No other entry changes on an update.

Test Plan:
1. Reset, then sweep iPCF = 0x0..0x3C step 4 -> oHitF=0, oPredTakenF=0, oPredTargetF=0 on every cycle.
2. Update {PC=0x100, taken=1, target=0x40}, then iPCF=0x100 the next cycle -> oHitF=1, oPredTakenF=1 (ctr=10), oPredTargetF=0x40. In the update cycle itself, iPCF=0x100 -> oHitF=0 (no bypass).
3. Counter saturation on PC=0x100:
   - Three taken updates -> ctr=11; prediction stays taken.
   - Then two not-taken updates -> ctr=01, oPredTakenF=0, oHitF=1, target still 0x40.
   - Then two more not-taken -> ctr=00, still no wrap.
4. Aliasing (ENTRIES=16): train PC=0x100 taken->0x40, then update PC=0x500 taken->0x80 (same index, different tag):
   - iPCF=0x100 -> oHitF=0.
   - iPCF=0x500 -> oPredTakenF=1, oPredTargetF=0x80.
   - A not-taken update to an untrained PC=0x204 leaves that entry invalid.
5. Train PC=0x100 taken, then assert iRst together with an update {PC=0x104, taken=1} -> after the edge, both 0x100 and 0x104 miss; a taken update the next cycle allocates with ctr=10.
6. Closed loop with the PC register: backward loop branch at 0x20 -> 0x10, taken 4 times then not taken.
   - From the second iteration, fetch redirects to 0x10 with no decode recovery.
   - The final not-taken iteration mispredicts once, and its update moves ctr toward not-taken.

Source files
------------

// File: rtl/branch_predictor_f.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, combinational lookup and resolved-branch training.
module branch_predictor_f #(
  parameter int ENTRIES = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iPCF,
  output logic        oPredTakenF,
  output logic [31:0] oPredTargetF,
  output logic        oHitF,
  input  logic        iUpdateEn,
  input  logic [31:0] iUpdatePC,
  input  logic        iUpdateTaken,
  input  logic [31:0] iUpdateTarget
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]   tagQ    [ENTRIES];
  logic [31:0]        targetQ [ENTRIES];
  logic [1:0]         ctrQ    [ENTRIES];

  logic [IDX_W-1:0] lookIdx;
  logic [TAG_W-1:0] lookTag;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic             unusedPcLsb;

  function automatic logic [1:0] satInc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] satDec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign lookIdx     = iPCF[IDX_W+1:2];
  assign lookTag     = iPCF[31:IDX_W+2];
  assign updIdx      = iUpdatePC[IDX_W+1:2];
  assign updTag      = iUpdatePC[31:IDX_W+2];
  assign unusedPcLsb = ^{iPCF[1:0], iUpdatePC[1:0]};

  // Lookup reads the stored state directly, so a same-cycle update is not bypassed.
  always_comb begin
    oHitF        = validQ[lookIdx] && (tagQ[lookIdx] == lookTag);
    oPredTakenF  = oHitF && ctrQ[lookIdx][1];
    oPredTargetF = oHitF ? targetQ[lookIdx] : 32'h0;
  end

  assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= 32'h0;
        ctrQ[i]    <= 2'b01;
      end
    end else if (iUpdateEn) begin
      if (updHit) begin
        if (iUpdateTaken) begin
          ctrQ[updIdx]    <= satInc(ctrQ[updIdx]);
          targetQ[updIdx] <= iUpdateTarget;
        end else begin
          ctrQ[updIdx] <= satDec(ctrQ[updIdx]);
        end
      end else if (iUpdateTaken) begin
        // Taken miss replaces whatever occupied the slot, starting weakly taken.
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        targetQ[updIdx] <= iUpdateTarget;
        ctrQ[updIdx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_f.sv
// Self-checking bench for branch_predictor_f: vector table, hand sequences
// (reset/update collision, closed fetch loop) and a randomized model comparison.
module tb_branch_predictor_f;

  logic        iClk;
  logic        iRst;
  logic [31:0] iPCF;
  logic        oPredTakenF;
  logic [31:0] oPredTargetF;
  logic        oHitF;
  logic        iUpdateEn;
  logic [31:0] iUpdatePC;
  logic        iUpdateTaken;
  logic [31:0] iUpdateTarget;

  int checks = 0;
  int errors = 0;

  branch_predictor_f #(.ENTRIES(16)) dut (
    .iClk(iClk), .iRst(iRst), .iPCF(iPCF),
    .oPredTakenF(oPredTakenF), .oPredTargetF(oPredTargetF), .oHitF(oHitF),
    .iUpdateEn(iUpdateEn), .iUpdatePC(iUpdatePC),
    .iUpdateTaken(iUpdateTaken), .iUpdateTarget(iUpdateTarget)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference model: one slot per index, holding the branch's word address.
  bit          mValid [16];
  logic [29:0] mLine  [16];
  logic [31:0] mTgt   [16];
  int          mCtr   [16];

  function automatic int idxOf(input logic [31:0] pc);
    return int'(pc[31:2]) % 16;
  endfunction

  function automatic void mPredict(input logic [31:0] pc, output bit hit,
                                   output bit tk, output logic [31:0] tgt);
    int i;
    i   = idxOf(pc);
    hit = mValid[i] && (mLine[i] == pc[31:2]);
    tk  = hit && (mCtr[i] >= 2);
    tgt = hit ? mTgt[i] : 32'h0;
  endfunction

  function automatic void mUpdate(input bit r, input bit en, input logic [31:0] pc,
                                  input bit tk, input logic [31:0] tgt);
    int i;
    bit hit;
    if (r) begin
      for (int k = 0; k < 16; k++) begin
        mValid[k] = 0; mLine[k] = '0; mTgt[k] = 32'h0; mCtr[k] = 1;
      end
    end else if (en) begin
      i   = idxOf(pc);
      hit = mValid[i] && (mLine[i] == pc[31:2]);
      if (hit) begin
        if (tk) begin
          mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
          mTgt[i] = tgt;
        end else begin
          mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
        end
      end else if (tk) begin
        mValid[i] = 1; mLine[i] = pc[31:2]; mTgt[i] = tgt; mCtr[i] = 2;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit en, input logic [31:0] upc, input bit tk,
                       input logic [31:0] utgt, input logic [31:0] pcf);
    iRst = r; iUpdateEn = en; iUpdatePC = upc; iUpdateTaken = tk;
    iUpdateTarget = utgt; iPCF = pcf;
    #1;
  endtask

  task automatic clockEdge();
    mUpdate(iRst, iUpdateEn, iUpdatePC, iUpdateTaken, iUpdateTarget);
    @(posedge iClk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [31:0] upc;
    bit          utk;
    logic [31:0] utgt;
    logic [31:0] pcf;
    bit          eHit;
    bit          eTk;
    logic [31:0] eTgt;
  } vec_t;

  vec_t vecs [30];

  logic [31:0] pool [6];

  initial begin
    bit          mh, mt;
    logic [31:0] mg;
    logic [31:0] pc, nextPc, pendPC;
    bit          pending, pendTaken, pendPred, mispred;
    logic [31:0] pendTgt;
    bit          predRec [6];
    int          iter, recov, cyc;

    // rst en upc utk utgt pcf -> hit taken target
    vecs[0]  = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 0, 0, 32'h0};
    vecs[1]  = '{0, 0, 32'h0,   0, 32'h0,    32'h100, 1, 1, 32'h40};
    vecs[2]  = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 1, 1, 32'h40};
    vecs[3]  = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 1, 1, 32'h40};
    vecs[4]  = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 1, 1, 32'h40};
    vecs[5]  = '{0, 1, 32'h100, 0, 32'h0,    32'h100, 1, 1, 32'h40};
    vecs[6]  = '{0, 1, 32'h100, 0, 32'h0,    32'h100, 1, 1, 32'h40};
    vecs[7]  = '{0, 0, 32'h0,   0, 32'h0,    32'h100, 1, 0, 32'h40};
    vecs[8]  = '{0, 1, 32'h100, 0, 32'h0,    32'h100, 1, 0, 32'h40};
    vecs[9]  = '{0, 1, 32'h100, 0, 32'h0,    32'h100, 1, 0, 32'h40};
    vecs[10] = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 1, 0, 32'h40};
    vecs[11] = '{0, 0, 32'h0,   0, 32'h0,    32'h100, 1, 0, 32'h40};
    vecs[12] = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 1, 0, 32'h40};
    vecs[13] = '{0, 1, 32'h500, 1, 32'h80,   32'h100, 1, 1, 32'h40};
    vecs[14] = '{0, 0, 32'h0,   0, 32'h0,    32'h100, 0, 0, 32'h0};
    vecs[15] = '{0, 0, 32'h0,   0, 32'h0,    32'h500, 1, 1, 32'h80};
    vecs[16] = '{0, 1, 32'h204, 0, 32'hDEAD, 32'h204, 0, 0, 32'h0};
    vecs[17] = '{0, 0, 32'h0,   0, 32'h0,    32'h204, 0, 0, 32'h0};
    vecs[18] = '{0, 0, 32'h0,   0, 32'h0,    32'h503, 1, 1, 32'h80};
    vecs[19] = '{0, 1, 32'h500, 1, 32'hC0,   32'h500, 1, 1, 32'h80};
    vecs[20] = '{0, 0, 32'h0,   0, 32'h0,    32'h500, 1, 1, 32'hC0};
    vecs[21] = '{0, 0, 32'h0,   0, 32'h0,    32'h104, 0, 0, 32'h0};
    vecs[22] = '{0, 1, 32'h100, 1, 32'h40,   32'h100, 0, 0, 32'h0};
    vecs[23] = '{1, 1, 32'h104, 1, 32'h44,   32'h100, 1, 1, 32'h40};
    vecs[24] = '{0, 0, 32'h0,   0, 32'h0,    32'h100, 0, 0, 32'h0};
    vecs[25] = '{0, 0, 32'h0,   0, 32'h0,    32'h104, 0, 0, 32'h0};
    vecs[26] = '{0, 1, 32'h104, 1, 32'h44,   32'h104, 0, 0, 32'h0};
    vecs[27] = '{0, 0, 32'h0,   0, 32'h0,    32'h104, 1, 1, 32'h44};
    vecs[28] = '{0, 1, 32'h104, 0, 32'h0,    32'h104, 1, 1, 32'h44};
    vecs[29] = '{0, 0, 32'h0,   0, 32'h0,    32'h104, 1, 0, 32'h44};

    pool[0] = 32'h100; pool[1] = 32'h500; pool[2] = 32'h104;
    pool[3] = 32'h140; pool[4] = 32'h900; pool[5] = 32'h3C;

    drive(1, 0, 0, 0, 0, 0);
    clockEdge();
    clockEdge();

    // Everything misses after reset.
    for (int a = 0; a <= 32'h3C; a += 4) begin
      drive(0, 0, 0, 0, 0, a);
      chk($sformatf("sweep_hit_%0h", a), oHitF, 0);
      chk($sformatf("sweep_tk_%0h", a), oPredTakenF, 0);
      chk($sformatf("sweep_tgt_%0h", a), oPredTargetF, 0);
      clockEdge();
    end

    for (int v = 0; v < 30; v++) begin
      drive(vecs[v].rst, vecs[v].en, vecs[v].upc, vecs[v].utk, vecs[v].utgt, vecs[v].pcf);
      chk($sformatf("vec%0d_hit", v), oHitF, vecs[v].eHit);
      chk($sformatf("vec%0d_tk", v), oPredTakenF, vecs[v].eTk);
      chk($sformatf("vec%0d_tgt", v), oPredTargetF, vecs[v].eTgt);
      clockEdge();
    end

    // Closed loop: branch at 0x20 back to 0x10, taken 4 times then falls through.
    drive(1, 0, 0, 0, 0, 0);
    clockEdge();
    pc = 32'h10; pending = 0; iter = 0; recov = 0; cyc = 0;
    pendPC = 0; pendTaken = 0; pendPred = 0; pendTgt = 0;
    for (int k = 0; k < 6; k++) predRec[k] = 0;
    while ((iter < 5 || pending) && cyc < 200) begin
      drive(0, pending, pendPC, pendTaken, 32'h10, pc);
      nextPc  = oPredTakenF ? oPredTargetF : pc + 32'd4;
      mispred = pending && ((pendPred != pendTaken) || (pendTaken && pendTgt != 32'h10));
      if (mispred) begin
        nextPc = pendTaken ? 32'h10 : 32'h24;
        recov++;
      end
      pending = 0;
      if (!mispred && pc == 32'h20) begin
        iter++;
        pending   = 1;
        pendPC    = pc;
        pendTaken = (iter <= 4);
        pendPred  = oPredTakenF;
        pendTgt   = oPredTargetF;
        predRec[iter] = oPredTakenF;
      end
      clockEdge();
      pc = nextPc;
      cyc++;
    end
    chk("loop_budget", (cyc < 200), 1);
    chk("loop_iter1_pred", predRec[1], 0);
    for (int k = 2; k <= 5; k++) chk($sformatf("loop_iter%0d_pred", k), predRec[k], 1);
    chk("loop_recoveries", recov, 2);
    chk("loop_pc_after", pc, 32'h24);
    drive(0, 0, 0, 0, 0, 32'h20);
    chk("loop_after_hit", oHitF, 1);
    chk("loop_after_tk", oPredTakenF, 1);
    clockEdge();
    drive(0, 1, 32'h20, 0, 32'h10, 32'h20);
    clockEdge();
    drive(0, 0, 0, 0, 0, 32'h20);
    chk("loop_weak_tk", oPredTakenF, 0);
    chk("loop_weak_tgt", oPredTargetF, 32'h10);
    clockEdge();

    // Randomized traffic against the model.
    drive(1, 0, 0, 0, 0, 0);
    clockEdge();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0),
            $urandom_range(0, 1),
            pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)),
            $urandom_range(0, 1),
            $urandom & 32'hFFFF_FFFC,
            pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)));
      mPredict(iPCF, mh, mt, mg);
      chk("rand_hit", oHitF, mh);
      chk("rand_tk", oPredTakenF, mt);
      chk("rand_tgt", oPredTargetF, mg);
      clockEdge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
